// File: rtl/inv_mix_columns_iter.sv
// Column-serial AES InvMixColumns: one column per clock through a shared GF(2^8) slice,
// with a valid/ready handshake on both sides and a per-transfer bypass for the last round.
module inv_mix_columns_iter #(
    parameter int BUS_WIDTH = 128
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [BUS_WIDTH-1:0] Data_In,
    input  logic                 Bypass,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [BUS_WIDTH-1:0] Data_Out,
    output logic                 Busy
);

    if (BUS_WIDTH != 128) begin : g_bad_width
        $error("inv_mix_columns_iter: BUS_WIDTH must be 128");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             col_q, col_d;
    logic [BUS_WIDTH-1:0]   buf_q, buf_d;
    logic [BUS_WIDTH-1:0]   res_q, res_d;
    logic                   byp_q, byp_d;
    logic [4:0]             sh;
    logic [7:0]             a [4];
    logic [7:0]             b [4];

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] v);
        return xt(xt(xt(v))) ^ v;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] v);
        return xt(xt(xt(v))) ^ xt(v) ^ v;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] v);
        return xt(xt(xt(v))) ^ xt(xt(v)) ^ v;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] v);
        return xt(xt(xt(v))) ^ xt(xt(v)) ^ xt(v);
    endfunction

    // Column c sits at bit offset 8*(3-c) within each row word; 3-c is ~c for 2 bits.
    assign sh = {~col_q, 3'b000};

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r] = buf_q[32*r + 32'(sh) +: 8];
        end
        if (byp_q) begin
            for (int r = 0; r < 4; r++) begin
                b[r] = a[r];
            end
        end else begin
            b[0] = mule(a[0]) ^ mulb(a[1]) ^ muld(a[2]) ^ mul9(a[3]);
            b[1] = mul9(a[0]) ^ mule(a[1]) ^ mulb(a[2]) ^ muld(a[3]);
            b[2] = muld(a[0]) ^ mul9(a[1]) ^ mule(a[2]) ^ mulb(a[3]);
            b[3] = mulb(a[0]) ^ muld(a[1]) ^ mul9(a[2]) ^ mule(a[3]);
        end
    end

    assign In_Ready  = !Rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && Out_Ready));
    assign Out_Valid = (state_q == S_DONE);
    assign Busy      = (state_q == S_BUSY);
    assign Data_Out  = res_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        buf_d   = buf_q;
        byp_d   = byp_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (In_Valid) begin
                    buf_d   = Data_In;
                    byp_d   = Bypass;
                    col_d   = 2'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int r = 0; r < 4; r++) begin
                    res_d[32*r + 32'(sh) +: 8] = b[r];
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A new state may be taken in the same cycle the result leaves.
                if (Out_Ready) begin
                    if (In_Valid) begin
                        buf_d   = Data_In;
                        byp_d   = Bypass;
                        col_d   = 2'd0;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            col_q   <= 2'd0;
            buf_q   <= '0;
            byp_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
            byp_q   <= byp_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: known-answer table, handshake corner cases and
// random round trips through a forward MixColumns model.
module tb_inv_mix_columns_iter;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         In_Valid = 1'b0;
    logic         In_Ready;
    logic [127:0] Data_In = '0;
    logic         Bypass = 1'b0;
    logic         Out_Valid;
    logic         Out_Ready = 1'b1;
    logic [127:0] Data_Out;
    logic         Busy;

    int checks = 0;
    int errors = 0;

    inv_mix_columns_iter #(.BUS_WIDTH(128)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Data_In   (Data_In),
        .Bypass    (Bypass),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Data_Out  (Data_Out),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [127:0] din;
        logic         byp;
        logic [127:0] expv;
    } vec_t;

    vec_t tbl [5];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // State byte (row r, column c) from four column words given rows 0..3 high to low.
    function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0]  cols [4];
        logic [127:0] s;
        cols = '{c0, c1, c2, c3};
        s = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[32*r + 8*(3-c) +: 8] = cols[c][8*(3-r) +: 8];
        return s;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00;
        aa = x;
        bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
        return s[32*r + 8*(3-c) +: 8];
    endfunction

    function automatic logic [127:0] mix_fwd(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[32*r + 8*(3-c) +: 8] = gmul(8'h02, gb(s, r, c)) ^ gmul(8'h03, gb(s, (r+1)%4, c))
                                       ^ gb(s, (r+2)%4, c) ^ gb(s, (r+3)%4, c);
        return o;
    endfunction

    task automatic run_xfer(input logic [127:0] din, input logic byp,
                            input logic [127:0] expv, input string nm);
        int n;
        In_Valid = 1'b1;
        Data_In  = din;
        Bypass   = byp;
        #1;
        n = 0;
        while (!In_Ready && n < 20) begin
            step();
            n++;
        end
        chk({nm, " ready"}, {127'd0, In_Ready}, 128'd1);
        step();
        In_Valid = 1'b0;
        Bypass   = 1'b0;
        n = 0;
        while (!Out_Valid && n < 20) begin
            step();
            n++;
        end
        chk({nm, " latency"}, 128'(n), 128'd4);
        chk({nm, " data"}, Data_Out, expv);
        step();
    endtask

    logic [127:0] fips_in, fips_out, held, sa, sb, orig;
    logic         rb;
    int           n, t1, t2;

    initial begin
        fips_in  = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6);
        fips_out = mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5);
        tbl[0] = '{fips_in, 1'b0, fips_out};
        tbl[1] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 128'h00112233445566778899aabbccddeeff};
        tbl[2] = '{128'h0, 1'b0, 128'h0};
        tbl[3] = '{{16{8'h01}}, 1'b0, {16{8'h01}}};
        tbl[4] = '{fips_in, 1'b1, fips_in};

        // Reset held with a pending request
        Rst = 1'b1;
        In_Valid = 1'b1;
        Data_In = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst in_ready", {127'd0, In_Ready}, 128'd0);
            chk("rst out_valid", {127'd0, Out_Valid}, 128'd0);
            chk("rst data_out", Data_Out, 128'd0);
            chk("rst busy", {127'd0, Busy}, 128'd0);
        end
        In_Valid = 1'b0;
        Rst = 1'b0;
        step();
        chk("post-rst in_ready", {127'd0, In_Ready}, 128'd1);
        chk("post-rst busy", {127'd0, Busy}, 128'd0);

        for (int i = 0; i < 5; i++)
            run_xfer(tbl[i].din, tbl[i].byp, tbl[i].expv, $sformatf("tbl%0d", i));

        // Backpressure: result must hold and new requests must be ignored
        Out_Ready = 1'b0;
        In_Valid = 1'b1;
        Data_In = fips_in;
        Bypass = 1'b0;
        step();
        In_Valid = 1'b0;
        n = 0;
        while (!Out_Valid && n < 20) begin
            step();
            n++;
        end
        chk("bp latency", 128'(n), 128'd4);
        held = Data_Out;
        chk("bp data", held, fips_out);
        In_Valid = 1'b1;
        Data_In = 128'h0;
        Bypass = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp in_ready", {127'd0, In_Ready}, 128'd0);
            step();
            chk("bp out_valid", {127'd0, Out_Valid}, 128'd1);
            chk("bp hold", Data_Out, fips_out);
        end
        In_Valid = 1'b0;
        Bypass = 1'b0;
        Out_Ready = 1'b1;
        step();
        chk("bp release valid", {127'd0, Out_Valid}, 128'd0);
        chk("bp retain", Data_Out, fips_out);
        step();
        chk("bp no capture", {127'd0, Busy}, 128'd0);

        // Back-to-back: second state accepted as the first leaves
        sa = 128'h00112233445566778899aabbccddeeff;
        sb = {$urandom, $urandom, $urandom, $urandom};
        In_Valid = 1'b1;
        Data_In = mix_fwd(sa);
        step();
        Data_In = mix_fwd(sb);
        n = 0;
        while (!Out_Valid && n < 20) begin
            step();
            n++;
        end
        t1 = n;
        chk("b2b first", Data_Out, sa);
        chk("b2b ready", {127'd0, In_Ready}, 128'd1);
        step();
        In_Valid = 1'b0;
        n++;
        while (!Out_Valid && n < 40) begin
            step();
            n++;
        end
        t2 = n;
        chk("b2b spacing", 128'(t2 - t1), 128'd5);
        chk("b2b second", Data_Out, sb);
        step();

        // Random round trips
        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0);
            run_xfer(rb ? orig : mix_fwd(orig), rb, orig, $sformatf("rand%0d", i));
        end

        // Reset while the third column is being computed
        In_Valid = 1'b1;
        Data_In = mix_fwd(fips_in);
        step();
        In_Valid = 1'b0;
        step();
        step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("midrst busy", {127'd0, Busy}, 128'd0);
        chk("midrst data", Data_Out, 128'd0);
        #1;
        chk("midrst in_ready", {127'd0, In_Ready}, 128'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (Out_Valid) n++;
        end
        chk("midrst no output", 128'(n), 128'd0);
        chk("midrst data hold", Data_Out, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_iter.md
Name: inv_mix_columns_iter

Overview:
Column-serial AES InvMixColumns engine for the decryption datapath, the inverse of the encryption MixColumns stage. It accepts a 128-bit state over a valid/ready handshake and multiplies each column by the inverse matrix (0e 0b 0d 09 circulant) in GF(2^8) mod x^8+x^4+x^3+x+1. It processes one column per clock to reuse a single 4-byte multiplier slice. It holds the result until the downstream round logic accepts it. A per-transfer bypass flag covers the final decryption round, where no InvMixColumns is applied.

Parameters:
BUS_WIDTH, 128, state width. Only 128 is legal; any other value is an elaboration error.

Ports:
Clk  input  1  clock, all logic on the rising edge
Rst  input  1  synchronous, active-high reset
In_Valid  input  1  Data_In and Bypass are valid
In_Ready  output  1  engine can accept a state this cycle
Data_In  input  BUS_WIDTH  state to transform
Bypass  input  1  sampled with Data_In; 1 = pass the state through unchanged
Out_Valid  output  1  Data_Out holds a completed state
Out_Ready  input  1  downstream accepts Data_Out
Data_Out  output  BUS_WIDTH  transformed state, registered
Busy  output  1  high in the BUSY state

Behaviour:
- Reset (Rst=1 at a rising edge): state=IDLE, column counter=0, Data_Out=0, Out_Valid=0, Busy=0, internal buffers=0. Reset mid-operation discards the in-flight state and produces no output. In_Ready is 0 while Rst is high.
- State layout: the byte at row r, column c is Data[32*r + 8*(3-c) +: 8]. Column 0 rows 0..3 are [31:24], [63:56], [95:88], [127:120]. The same layout applies to Data_Out.
- Per-column math, with inputs a0..a3 and outputs b0..b3 (rows 0..3):
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Build all products from xtime chains (x2, x4, x8 plus XORs). No lookup tables.
- FSM states:
  - IDLE: In_Ready=1. On In_Valid: latch Data_In into the input buffer, latch Bypass, set counter=0, go to BUSY.
  - BUSY: Busy=1, In_Ready=0. Each cycle, compute column[counter] and write its 4 bytes into the result register; other columns are untouched. If Bypass was latched, copy the column unchanged. Counter increments; after column 3 is written, go to DONE.
  - DONE: Out_Valid=1 and Data_Out is stable. On Out_Ready: transfer completes. If In_Valid is also high in that same cycle, accept the new state and go to BUSY (back-to-back). Otherwise go to IDLE.
- In_Ready = (state==IDLE) | (state==DONE & Out_Ready), combinational.
- Latency: accept at edge T; Out_Valid rises after edge T+4. Throughput is one state per 5 cycles with Out_Ready held high.
- Data_Out changes only during BUSY column writes. It retains its last value in IDLE and is never forced to 0 except by reset.
- In_Valid while not ready is ignored; the source must hold its data. The engine never captures in BUSY.
- Bypass has the same latency as a normal transfer, so the pipeline timing is uniform.
- Out_Ready held low in DONE stalls indefinitely; Data_Out and Out_Valid stay stable.
- Out_Ready outside DONE has no effect.

Test Plan:
- Reset, then hold Rst=1 for 3 cycles with In_Valid=1 -> In_Ready=0, Out_Valid=0, Data_Out=0, Busy=0. Release Rst -> In_Ready=1 on the next cycle.
- FIPS vectors, with all four columns loaded in one state: column 0 = 8e 4d a1 bc, column 1 = 9f dc 58 9d, column 2 = 01 01 01 01, column 3 = d5 d5 d7 d6 (rows 0..3). Bypass=0, Out_Ready=1 -> exactly 4 cycles after accept, Data_Out columns are db 13 53 45 / f2 0a 22 5c / 01 01 01 01 / d4 d4 d4 d5.
- Bypass=1 with Data_In=0x00112233445566778899aabbccddeeff -> Data_Out equals Data_In with the same 4-cycle latency.
- Backpressure: Out_Ready=0 for 10 cycles after Out_Valid -> Data_Out and Out_Valid stay stable, In_Ready=0. A new In_Valid in that window is not captured.
- Back-to-back: In_Valid held high with two states and Out_Ready=1 -> second accepted in the same cycle the first is consumed. Out_Valid pulses 5 cycles apart, both results correct.
- Round trip: 1000 random states through a MixColumns reference model, then this block -> output equals the original state. Also assert Rst in BUSY at counter=2 -> FSM returns to IDLE, no Out_Valid pulse, Data_Out=0.
